univ_shift_reg: RTL and testbench

Parametrised universal shift register: the successor to the fixed 4-bit serial-in right-shift register used in the shift-register lab. It supports configurable width, eight operating modes (shift, rotate, arithmetic shift, parallel load, clear, hold), a registered serial-out bit and a frame counter. The frame counter pulses `frame_valid` when WIDTH shift operations have assembled a full word. It sits between a serial source (switch or bit stream) and parallel consumers such as LEDs or a 7-segment decoder.

---
 rtl/univ_shift_reg.sv | 114 +++++++++++
 tb/tb_univ_shift_reg.sv | 134 +++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register: shift/rotate/arithmetic-shift, parallel load, clear and hold,
// with a registered serial-out bit and a frame counter that pulses after WIDTH shift ops.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned CntW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             x,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] out,
  output logic             sout,
  output logic             frame_valid,
  output logic [CntW-1:0]  shift_cnt
);

  typedef enum logic [2:0] {
    ModeHold  = 3'b000,
    ModeShr   = 3'b001,
    ModeShl   = 3'b010,
    ModeRor   = 3'b011,
    ModeRol   = 3'b100,
    ModeLoad  = 3'b101,
    ModeClear = 3'b110,
    ModeAsr   = 3'b111
  } mode_e;

  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] out_q, out_d;
  logic             sout_q, sout_d;
  logic             fv_q, fv_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             is_shift;

  always_comb begin
    out_d    = out_q;
    sout_d   = sout_q;
    cnt_d    = cnt_q;
    fv_d     = 1'b0;
    is_shift = 1'b0;
    if (en) begin
      case (mode_e'(mode))
        ModeShr: begin
          out_d    = {x, out_q[WIDTH-1:1]};
          sout_d   = out_q[0];
          is_shift = 1'b1;
        end
        ModeShl: begin
          out_d    = {out_q[WIDTH-2:0], x};
          sout_d   = out_q[WIDTH-1];
          is_shift = 1'b1;
        end
        ModeRor: begin
          out_d    = {out_q[0], out_q[WIDTH-1:1]};
          sout_d   = out_q[0];
          is_shift = 1'b1;
        end
        ModeRol: begin
          out_d    = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
          sout_d   = out_q[WIDTH-1];
          is_shift = 1'b1;
        end
        ModeAsr: begin
          out_d    = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
          sout_d   = out_q[0];
          is_shift = 1'b1;
        end
        ModeLoad: begin
          out_d  = load_data;
          sout_d = 1'b0;
          cnt_d  = '0;
        end
        ModeClear: begin
          out_d  = '0;
          sout_d = 1'b0;
          cnt_d  = '0;
        end
        default: ;
      endcase
    end
    // All shift kinds share one frame count; wrapping from WIDTH-1 marks the boundary.
    if (is_shift) begin
      if (cnt_q == CntLast) begin
        cnt_d = '0;
        fv_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      sout_q <= 1'b0;
      fv_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      out_q  <= out_d;
      sout_q <= sout_d;
      fv_q   <= fv_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out         = out_q;
  assign sout        = sout_q;
  assign frame_valid = fv_q;
  assign shift_cnt   = cnt_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed test-plan steps followed by random
// operations, all compared against an arithmetic reference model.
module tb_univ_shift_reg;

  localparam int unsigned W    = 4;
  localparam int unsigned CntW = $clog2(W + 1);

  logic            clk = 1'b0;
  logic            reset, en, x;
  logic [2:0]      mode;
  logic [W-1:0]    load_data;
  logic [W-1:0]    out;
  logic            sout, frame_valid;
  logic [CntW-1:0] shift_cnt;

  int unsigned m_out, m_sout, m_fv, m_cnt;
  int errors = 0;
  int checks = 0;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .mode        (mode),
    .x           (x),
    .load_data   (load_data),
    .out         (out),
    .sout        (sout),
    .frame_valid (frame_valid),
    .shift_cnt   (shift_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: register value as an integer, frame count as shifts modulo W.
  task automatic model(input logic r, input logic e, input int unsigned md, input int unsigned xi,
                       input int unsigned ld);
    int unsigned mask = (1 << W) - 1;
    int unsigned lsb  = m_out & 1;
    int unsigned msb  = (m_out >> (W - 1)) & 1;
    bit shifted = 1'b0;
    m_fv = 0;
    if (r) begin
      m_out = 0; m_sout = 0; m_cnt = 0;
    end else if (e) begin
      case (md)
        1: begin m_sout = lsb; m_out = (m_out >> 1) | (xi << (W - 1)); shifted = 1; end
        2: begin m_sout = msb; m_out = ((m_out << 1) | xi) & mask; shifted = 1; end
        3: begin m_sout = lsb; m_out = (m_out >> 1) | (lsb << (W - 1)); shifted = 1; end
        4: begin m_sout = msb; m_out = ((m_out << 1) | msb) & mask; shifted = 1; end
        5: begin m_out = ld & mask; m_sout = 0; m_cnt = 0; end
        6: begin m_out = 0; m_sout = 0; m_cnt = 0; end
        7: begin m_sout = lsb; m_out = (m_out >> 1) | (msb << (W - 1)); shifted = 1; end
        default: ;
      endcase
      if (shifted) begin
        m_cnt = (m_cnt + 1) % W;
        m_fv  = (m_cnt == 0) ? 1 : 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [2:0] md, input logic xi,
                      input logic [W-1:0] ld);
    reset = r; en = e; mode = md; x = xi; load_data = ld;
    @(posedge clk);
    model(r, e, md, xi, ld);
    #1;
    chk("out", out, m_out);
    chk("sout", sout, m_sout);
    chk("frame_valid", frame_valid, m_fv);
    chk("shift_cnt", shift_cnt, m_cnt);
  endtask

  initial begin
    logic [3:0] xs;
    m_out = 0; m_sout = 0; m_fv = 0; m_cnt = 0;
    reset = 1'b1; en = 1'b0; mode = 3'b000; x = 1'b0; load_data = '0;
    @(negedge clk);

    step(1, 1, 3'b001, 1, '0);
    // Serial-in right shift of 1,0,1,1.
    xs = 4'b1101;
    for (int i = 0; i < 4; i++) step(0, 1, 3'b001, xs[i], '0);
    chk("tp_shr_out", out, 4'hD);
    chk("tp_shr_fv", frame_valid, 1);

    step(0, 1, 3'b101, 0, 4'b1001);
    for (int i = 0; i < 4; i++) step(0, 1, 3'b011, 1, '0);
    chk("tp_ror_out", out, 4'h9);
    chk("tp_ror_fv", frame_valid, 1);

    step(0, 1, 3'b101, 0, 4'b1000);
    step(0, 1, 3'b111, 0, '0);
    step(0, 1, 3'b111, 1, '0);
    chk("tp_asr_out", out, 4'hE);
    step(0, 1, 3'b010, 1, '0);
    chk("tp_shl_out", out, 4'hD);
    chk("tp_shl_sout", sout, 1);

    step(0, 1, 3'b110, 0, '0);
    step(0, 1, 3'b001, 1, '0);
    step(0, 1, 3'b001, 1, '0);
    for (int i = 0; i < 3; i++) step(0, 0, 3'b001, 0, '0);
    step(0, 1, 3'b001, 0, '0);
    step(0, 1, 3'b001, 1, '0);
    chk("tp_en_fv", frame_valid, 1);

    for (int i = 0; i < 3; i++) step(0, 1, 3'b001, 1, '0);
    step(1, 1, 3'b001, 1, '0);
    chk("tp_rst_cnt", shift_cnt, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 3'b001, i[0], '0);
    step(0, 1, 3'b101, 0, 4'b0110);
    chk("tp_load_after_pulse_fv", frame_valid, 0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 7) != 0),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
